// File: rtl/child_runner_if.sv
// Bus between child_runner and the per-step movement block.
// The runner presents the current position and move. The block answers with the next position.
interface child_runner_if;
    logic [1:0] mv_dir;
    logic [2:0] mv_x;
    logic [2:0] mv_y;
    logic       mv_alive;
    logic [2:0] mv_xnew;
    logic [2:0] mv_ynew;
    logic       mv_alivenew;

    modport master (
        output mv_dir, mv_x, mv_y, mv_alive,
        input  mv_xnew, mv_ynew, mv_alivenew
    );

    modport slave (
        input  mv_dir, mv_x, mv_y, mv_alive,
        output mv_xnew, mv_ynew, mv_alivenew
    );
endinterface

// File: rtl/child_runner.sv
// Steps one child's genome through the movement block, one move per cycle, from (0,0).
// It stops on death, on reaching (7,7), or when the genome is exhausted, then registers the results and fitness.
module child_runner #(
    parameter int GENE_LEN = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2*GENE_LEN-1:0] genome,
    child_runner_if.master        mv,
    output logic                  busy,
    output logic                  done,
    output logic [2:0]            final_x,
    output logic [2:0]            final_y,
    output logic                  final_alive,
    output logic                  reached_goal,
    output logic [5:0]            steps_used,
    output logic [7:0]            fitness
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [5:0] LAST_IDX  = 6'(GENE_LEN - 1);
    localparam logic [7:0] GOAL_BASE = 8'(64 + GENE_LEN);

    state_t                state, state_nx;
    logic [2*GENE_LEN-1:0] gsh;
    logic [2:0]            x, y;
    logic                  alive;
    logic [5:0]            idx;

    logic                  goal_hit;
    logic                  term;
    logic [5:0]            step_cnt;
    logic [3:0]            pos_sum;
    logic [7:0]            fit_nx;

    // Termination is judged on what the movement block returns for this step.
    assign goal_hit = mv.mv_alivenew && (mv.mv_xnew == 3'd7) && (mv.mv_ynew == 3'd7);
    assign term     = !mv.mv_alivenew || goal_hit || (idx == LAST_IDX);
    assign step_cnt = idx + 6'd1;
    assign pos_sum  = {1'b0, mv.mv_xnew} + {1'b0, mv.mv_ynew};

    always_comb begin
        fit_nx = 8'd0;
        if (goal_hit)
            fit_nx = GOAL_BASE - {2'b00, step_cnt};
        else if (mv.mv_alivenew)
            fit_nx = {4'b0000, pos_sum};
        else
            fit_nx = {5'b00000, pos_sum[3:1]};
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (term)  state_nx = DONE;
            DONE:    state_nx = start ? RUN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy        = (state == RUN);
    assign done        = (state == DONE);
    assign mv.mv_dir   = busy ? gsh[2*GENE_LEN-1 -: 2] : 2'd0;
    assign mv.mv_x     = x;
    assign mv.mv_y     = y;
    assign mv.mv_alive = alive;

    // Walk state. The genome is shifted so the current move always sits in the MSBs.
    always_ff @(posedge clk) begin
        if (rst) begin
            gsh   <= '0;
            x     <= 3'd0;
            y     <= 3'd0;
            alive <= 1'b0;
            idx   <= 6'd0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        gsh   <= genome;
                        x     <= 3'd0;
                        y     <= 3'd0;
                        alive <= 1'b1;
                        idx   <= 6'd0;
                    end
                end
                RUN: begin
                    gsh   <= gsh << 2;
                    x     <= mv.mv_xnew;
                    y     <= mv.mv_ynew;
                    alive <= mv.mv_alivenew;
                    idx   <= step_cnt;
                end
                default: ;
            endcase
        end
    end

    // Results stay put until the next terminating step, so a new start leaves them stale but intact.
    always_ff @(posedge clk) begin
        if (rst) begin
            final_x      <= 3'd0;
            final_y      <= 3'd0;
            final_alive  <= 1'b0;
            reached_goal <= 1'b0;
            steps_used   <= 6'd0;
            fitness      <= 8'd0;
        end else if (busy && term) begin
            final_x      <= mv.mv_xnew;
            final_y      <= mv.mv_ynew;
            final_alive  <= mv.mv_alivenew;
            reached_goal <= goal_hit;
            steps_used   <= step_cnt;
            fitness      <= fit_nx;
        end
    end

endmodule

// File: tb/tb_child_runner.sv
// Directed bench for child_runner: a movement-block model on an 8x8 map, a table of genomes, and control corner cases.
module tb_child_runner;
    localparam int GL = 16;

    logic          clk = 1'b0;
    logic          rst, start;
    logic [2*GL-1:0] genome;
    logic          busy, done, final_alive, reached_goal;
    logic [2:0]    final_x, final_y;
    logic [5:0]    steps_used;
    logic [7:0]    fitness;
    logic [63:0]   map;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    child_runner_if mv();

    child_runner #(.GENE_LEN(GL)) dut (
        .clk(clk), .rst(rst), .start(start), .genome(genome), .mv(mv),
        .busy(busy), .done(done), .final_x(final_x), .final_y(final_y),
        .final_alive(final_alive), .reached_goal(reached_goal),
        .steps_used(steps_used), .fitness(fitness)
    );

    // Movement block: a step off the board or into a wall kills the child and leaves it in place.
    int   tx, ty;
    logic inb, wall, ok;
    always_comb begin
        tx = int'(mv.mv_x);
        ty = int'(mv.mv_y);
        case (mv.mv_dir)
            2'd0:    tx = tx + 1;
            2'd1:    tx = tx - 1;
            2'd2:    ty = ty + 1;
            default: ty = ty - 1;
        endcase
        inb  = (tx >= 0) && (tx <= 7) && (ty >= 0) && (ty <= 7);
        wall = inb ? map[63 - (ty * 8 + tx)] : 1'b0;
        ok   = mv.mv_alive && inb && !wall;
        mv.mv_alivenew = ok;
        mv.mv_xnew     = ok ? 3'(tx) : mv.mv_x;
        mv.mv_ynew     = ok ? 3'(ty) : mv.mv_y;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] g;
        logic [63:0] m;
        int          steps, fx, fy, alive, goal, fit;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start one run, optionally pulsing start during RUN, and check moves, latency and results.
    task automatic do_run(input vec_t v, input int pulse_at, input string tag);
        int          lat;
        int          k;
        logic [31:0] gs;
        map    = v.m;
        genome = v.g;
        start  = 1'b1;
        tick();
        start = 1'b0;
        lat   = 1;
        k     = 0;
        check({tag, " busy_after_start"}, busy, 1);
        while (!done && lat < 100) begin
            if (busy) begin
                gs = v.g << (2 * k);
                check({tag, " mv_dir"}, mv.mv_dir, gs[31:30]);
                k++;
            end
            if (lat == pulse_at) begin
                start  = 1'b1;
                genome = '1;
            end
            tick();
            start = 1'b0;
            lat++;
        end
        check({tag, " latency"}, lat, v.steps + 1);
        check({tag, " moves_presented"}, k, v.steps);
        check({tag, " steps_used"}, steps_used, v.steps);
        check({tag, " final_x"}, final_x, v.fx);
        check({tag, " final_y"}, final_y, v.fy);
        check({tag, " final_alive"}, final_alive, v.alive);
        check({tag, " reached_goal"}, reached_goal, v.goal);
        check({tag, " fitness"}, fitness, v.fit);
        check({tag, " mv_x_idle"}, mv.mv_x, v.fx);
        check({tag, " mv_dir_idle"}, mv.mv_dir, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dcount;
        vecs[0] = '{32'h0000_0000, 64'h0,                  8,  7, 0, 0, 0, 3};
        vecs[1] = '{32'h0002_AAAF, 64'h0,                  14, 7, 7, 1, 1, 66};
        vecs[2] = '{32'h0000_0000, 64'h4000_0000_0000_0000, 1, 0, 0, 0, 0, 0};
        vecs[3] = '{32'h1111_1111, 64'h0,                  16, 0, 0, 1, 0, 0};
        vecs[4] = '{32'h02EE_EEEE, 64'h0,                  16, 3, 1, 1, 0, 4};
        vecs[5] = '{32'hAA40_0000, 64'h0,                  5,  0, 4, 0, 0, 2};

        rst    = 1'b1;
        start  = 1'b0;
        genome = '0;
        map    = '0;
        repeat (2) tick();
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst mv_alive", mv.mv_alive, 0);
        check("rst mv_dir", mv.mv_dir, 0);
        check("rst fitness", fitness, 0);
        check("rst steps_used", steps_used, 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            do_run(vecs[i], -1, $sformatf("vec%0d", i));
            tick();
            check($sformatf("vec%0d done_one_cycle", i), done, 0);
            check($sformatf("vec%0d busy_idle", i), busy, 0);
        end

        do_run(vecs[0], 3, "pulse_in_run");
        tick();

        do_run(vecs[2], -1, "b2b_first");
        check("b2b done_before_restart", done, 1);
        do_run(vecs[1], -1, "b2b_second");

        // New run must not clear the previous results; then reset lands mid-run.
        tick();
        map    = '0;
        genome = '0;
        start  = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("hold busy", busy, 1);
        check("hold final_x", final_x, 7);
        check("hold reached_goal", reached_goal, 1);
        check("hold fitness", fitness, 66);
        rst = 1'b1;
        tick();
        check("midrst busy", busy, 0);
        check("midrst done", done, 0);
        check("midrst final_x", final_x, 0);
        check("midrst final_y", final_y, 0);
        check("midrst reached_goal", reached_goal, 0);
        check("midrst steps_used", steps_used, 0);
        check("midrst fitness", fitness, 0);
        check("midrst mv_x", mv.mv_x, 0);
        check("midrst mv_alive", mv.mv_alive, 0);
        rst    = 1'b0;
        dcount = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (done) dcount++;
        end
        check("midrst no_done_pulse", dcount, 0);

        rst   = 1'b1;
        start = 1'b1;
        tick();
        check("rst_and_start busy", busy, 0);
        rst   = 1'b0;
        start = 1'b0;
        tick();
        check("rst_and_start stays_idle", busy, 0);

        do_run(vecs[4], -1, "after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
